// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder_share_arb scheduler: FSM state encoding,
// default sizing, and the requester-index width.
package adder_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_OP_W    = 2;
  localparam int DEF_ADD_LAT = 1;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  // Width of the latency down-counter; ADD_LAT is at most 4.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/adder_share_arb_rr_picker.sv
// rr_picker: combinational round-robin priority encoder. The search starts
// at index ptr and wraps; the first asserted req bit found is the winner.
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int RID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RID_W-1:0]   ptr,
  output logic               any,
  output logic [RID_W-1:0]   winner
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest asserted bit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx[RID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin scheduler sharing one registered adder among
// NUM_REQ requesters. One operation is in flight at a time:
// IDLE (arbitrate) -> WAIT (adder latency) -> RESP (one-cycle response).
// Optional build macro ADDER_ARB_CHECK_EN adds a sum self-check that sets
// err_sticky on a mismatch between add_a+add_b and add_sum at capture.
//
// Handshake: a requester holds req high until its gnt bit pulses for one
// cycle; the pulse means its operands were captured. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_id/rsp_sum are valid with it.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int OP_W    = DEF_OP_W,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*OP_W-1:0]    op_a,
  input  logic [NUM_REQ*OP_W-1:0]    op_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [OP_W:0]              rsp_sum,
  output logic [OP_W-1:0]            add_a,
  output logic [OP_W-1:0]            add_b,
  input  logic [OP_W:0]              add_sum,
  output logic                       err_sticky,
  output logic [1:0]                 state_dbg
);

  localparam int RID_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [RID_W-1:0]   ptr_q, ptr_d;
  logic [RID_W-1:0]   cur_id_q, cur_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [RID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [OP_W:0]      rsp_sum_q, rsp_sum_d;
  logic [OP_W-1:0]    add_a_q, add_a_d;
  logic [OP_W-1:0]    add_b_q, add_b_d;
  logic               capture;

  logic               pick_any;
  logic [RID_W-1:0]   pick_winner;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .RID_W   (RID_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Next-state logic for arbitration, latency wait and response.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d    = NUM_REQ'(1) << pick_winner;
          add_a_d  = op_a[int'(pick_winner)*OP_W +: OP_W];
          add_b_d  = op_b[int'(pick_winner)*OP_W +: OP_W];
          cur_id_d = pick_winner;
          cnt_d    = CNT_W'(ADD_LAT);
          if (int'(pick_winner) == NUM_REQ - 1) ptr_d = '0;
          else                                  ptr_d = pick_winner + RID_W'(1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture     = 1'b1;
          rsp_sum_d   = add_sum;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

`ifdef ADDER_ARB_CHECK_EN
  // add_a_q/add_b_q hold the issued operands until the next grant, so they
  // serve as the reference copy for the sum check.
  logic err_q, err_d;
  logic [OP_W:0] exp_sum;

  // Reference sum and sticky mismatch flag update at the capture edge.
  always_comb begin
    exp_sum = {1'b0, add_a_q} + {1'b0, add_b_q};
    err_d   = err_q;
    if (capture && (exp_sum != add_sum)) err_d = 1'b1;
  end

  // Sticky error flop, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign err_sticky     = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed testbench for adder_share_arb with NUM_REQ=4, OP_W=2, ADD_LAT=1
// and a behavioural one-stage registered adder. Outputs are sampled on the
// falling clock edge; inputs change on the falling edge.
module tb_adder_share_arb;

  localparam int NUM_REQ = 4;
  localparam int OP_W    = 2;
  localparam int ADD_LAT = 1;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*OP_W-1:0] op_a;
  logic [NUM_REQ*OP_W-1:0] op_b;
  logic [NUM_REQ-1:0]      gnt;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [OP_W:0]           rsp_sum;
  logic [OP_W-1:0]         add_a;
  logic [OP_W-1:0]         add_b;
  logic [OP_W:0]           add_sum;
  logic                    err_sticky;
  logic [1:0]              state_dbg;

  logic [OP_W:0]           add_sum_r;
  logic                    corrupt;
  logic                    exp_err;

  int tests_run;
  int tests_failed;

  adder_share_arb #(
    .NUM_REQ (NUM_REQ),
    .OP_W    (OP_W),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .err_sticky (err_sticky),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural registered adder; corrupt flips the sum LSB.
  always_ff @(posedge clk) add_sum_r <= {1'b0, add_a} + {1'b0, add_b};
  assign add_sum = add_sum_r ^ {{OP_W{1'b0}}, corrupt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    op_a[i*OP_W +: OP_W] = a;
    op_b[i*OP_W +: OP_W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One full operation: grant edge, wait edge, capture edge, return edge.
  task automatic do_op(input string tag, input logic [3:0] e_gnt, input logic [OP_W-1:0] e_a,
                       input logic [OP_W-1:0] e_b, input logic [1:0] e_id, input logic [OP_W:0] e_sum);
    step();
    check({tag, ".gnt"}, gnt, e_gnt);
    check({tag, ".add_a"}, add_a, e_a);
    check({tag, ".add_b"}, add_b, e_b);
    check({tag, ".state_wait"}, state_dbg, 2'd1);
    step();
    check({tag, ".gnt_clear"}, gnt, 4'b0000);
    check({tag, ".no_rsp_early"}, rsp_valid, 1'b0);
    step();
    check({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    check({tag, ".rsp_id"}, rsp_id, e_id);
    check({tag, ".rsp_sum"}, rsp_sum, e_sum);
    step();
    check({tag, ".rsp_clear"}, rsp_valid, 1'b0);
    check({tag, ".state_idle"}, state_dbg, 2'd0);
    check({tag, ".add_a_hold"}, add_a, e_a);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = '0;
    op_a         = '0;
    op_b         = '0;
    corrupt      = 1'b0;
`ifdef ADDER_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset state
    step();
    step();
    check("rst.gnt", gnt, 4'b0000);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.rsp_id", rsp_id, 2'd0);
    check("rst.rsp_sum", rsp_sum, 3'd0);
    check("rst.add_a", add_a, 2'd0);
    check("rst.add_b", add_b, 2'd0);
    check("rst.err", err_sticky, 1'b0);
    check("rst.state", state_dbg, 2'd0);
    rst_n = 1'b1;
    step();
    check("idle.no_gnt", gnt, 4'b0000);

    // Single request: 3 + 2 = 5
    set_ops(0, 2'd3, 2'd2);
    req = 4'b0001;
    do_op("single", 4'b0001, 2'd3, 2'd2, 2'd0, 3'd5);
    req = 4'b0000;
    step();
    check("single.no_regrant", gnt, 4'b0000);

    // All requesting from ptr=0: rotation 0,1,2,3,0
    do_reset();
    set_ops(0, 2'd0, 2'd1);
    set_ops(1, 2'd1, 2'd2);
    set_ops(2, 2'd2, 2'd0);
    set_ops(3, 2'd3, 2'd3);
    req = 4'b1111;
    do_op("rr0", 4'b0001, 2'd0, 2'd1, 2'd0, 3'd1);
    do_op("rr1", 4'b0010, 2'd1, 2'd2, 2'd1, 3'd3);
    do_op("rr2", 4'b0100, 2'd2, 2'd0, 2'd2, 3'd2);
    do_op("rr3", 4'b1000, 2'd3, 2'd3, 2'd3, 3'd6);
    do_op("rr4", 4'b0001, 2'd0, 2'd1, 2'd0, 3'd1);

    // Lone requester 2 granted back-to-back: 1 + 1 = 2
    set_ops(2, 2'd1, 2'd1);
    req = 4'b0100;
    do_op("solo0", 4'b0100, 2'd1, 2'd1, 2'd2, 3'd2);
    do_op("solo1", 4'b0100, 2'd1, 2'd1, 2'd2, 3'd2);
    do_op("solo2", 4'b0100, 2'd1, 2'd1, 2'd2, 3'd2);

    // Boundary: 3 + 3 = 6 keeps the carry bit
    req = 4'b1000;
    do_op("maxsum", 4'b1000, 2'd3, 2'd3, 2'd3, 3'b110);
    req = 4'b0000;
    step();
    check("noreq.gnt", gnt, 4'b0000);
    check("noreq.state", state_dbg, 2'd0);

    // Reset during WAIT discards the operation
    set_ops(0, 2'd2, 2'd1);
    req = 4'b1111;
    step();
    check("mid.gnt", gnt, 4'b0001);
    check("mid.state", state_dbg, 2'd1);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("mid.rst_gnt", gnt, 4'b0000);
    check("mid.rst_state", state_dbg, 2'd0);
    check("mid.rst_add_a", add_a, 2'd0);
    check("mid.rst_add_b", add_b, 2'd0);
    check("mid.rst_rsp", rsp_valid, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid.no_rsp", rsp_valid, 1'b0);
    end
    req = 4'b1111;
    do_op("post_rst", 4'b0001, 2'd2, 2'd1, 2'd0, 3'd3);
    req = 4'b0000;

    // Corrupted adder output: response passes through, checker flags it
    set_ops(0, 2'd3, 2'd2);
    check("err.before", err_sticky, 1'b0);
    corrupt = 1'b1;
    req     = 4'b0001;
    do_op("corrupt", 4'b0001, 2'd3, 2'd2, 2'd0, 3'd4);
    check("err.set", err_sticky, exp_err);
    corrupt = 1'b0;
    do_op("clean", 4'b0001, 2'd3, 2'd2, 2'd0, 3'd5);
    check("err.held", err_sticky, exp_err);
    req = 4'b0000;
    do_reset();
    check("err.cleared", err_sticky, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
